// File: rtl/tinode_axil_pkg.sv
// Shared types and constants for the TInode AXI4-Lite register initiator.
package tinode_axil_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_RESP,
    ST_DRAIN
  } state_e;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // Size of the TInode register slave address window, in bytes.
  localparam int unsigned TINODE_WIN_BYTES = 512;

  // Width of the response-phase timeout counter (covers TIMEOUT_CYCLES up to 65535).
  localparam int unsigned TO_CNT_W = 16;

endpackage

// File: rtl/tinode_axil_timeout.sv
// Loadable down-counter guarding the B/R response wait. expired_o is high
// once the counter has walked down to zero.
module tinode_axil_timeout
  import tinode_axil_pkg::*;
#(
  parameter int unsigned CNT_W = TO_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: reload takes priority, otherwise decrement while enabled and non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                   cnt_d = load_val_i;
    else if (en_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/tinode_axil_initiator.sv
// AXI4-Lite initiator: runs one register read or write at a time for the
// firmware command port and returns data/response, with a response-phase
// timeout and a drain state that swallows a late B/R after a timeout.
module tinode_axil_initiator
  import tinode_axil_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              CLKReg,
  input  logic              axi_areset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] m_axil_awaddr,
  output logic [2:0]        m_axil_awprot,
  output logic              m_axil_awvalid,
  input  logic              m_axil_awready,
  output logic [31:0]       m_axil_wdata,
  output logic [3:0]        m_axil_wstrb,
  output logic              m_axil_wvalid,
  input  logic              m_axil_wready,
  input  logic [1:0]        m_axil_bresp,
  input  logic              m_axil_bvalid,
  output logic              m_axil_bready,
  output logic [ADDR_W-1:0] m_axil_araddr,
  output logic [2:0]        m_axil_arprot,
  output logic              m_axil_arvalid,
  input  logic              m_axil_arready,
  input  logic [31:0]       m_axil_rdata,
  input  logic [1:0]        m_axil_rresp,
  input  logic              m_axil_rvalid,
  output logic              m_axil_rready
);

  // Expiry is seen on the TIMEOUT_CYCLES-th wait cycle, so load one less.
  localparam logic [TO_CNT_W-1:0] TO_LOAD = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q;
  logic              is_wr_q;
  logic              cmd_ready_q, rsp_valid_q, rsp_timeout_q;
  logic [31:0]       rsp_rdata_q;
  logic [1:0]        rsp_resp_q;
  logic [ADDR_W-1:0] awaddr_q, araddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  logic              to_load, to_en, to_expired;
  logic              aw_done, w_done;
  logic [ADDR_W-1:0] addr_aligned;

  // Word alignment done as a mask so the dropped low bits stay in use.
  assign addr_aligned = cmd_addr & ~ADDR_W'(3);

  // A channel is finished once its valid has dropped or handshakes this cycle.
  assign aw_done = !awvalid_q || m_axil_awready;
  assign w_done  = !wvalid_q  || m_axil_wready;

  // Counter reloads outside the response waits, so it is fresh on entry.
  assign to_load = (state_q != ST_WR_RESP) && (state_q != ST_RD_RESP);
  assign to_en   = !to_load;

  tinode_axil_timeout #(.CNT_W(TO_CNT_W)) u_timeout (
    .clk_i      (CLKReg),
    .rst_i      (axi_areset),
    .load_i     (to_load),
    .en_i       (to_en),
    .load_val_i (TO_LOAD),
    .expired_o  (to_expired)
  );

  // Transaction FSM with all bus/response outputs registered.
  always_ff @(posedge CLKReg or posedge axi_areset) begin
    if (axi_areset) begin
      state_q       <= ST_IDLE;
      is_wr_q       <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            is_wr_q     <= cmd_write;
            if (cmd_write) begin
              awaddr_q  <= addr_aligned;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR_REQ;
            end else begin
              araddr_q  <= addr_aligned;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (m_axil_awready) awvalid_q <= 1'b0;
          if (m_axil_wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          // A B arriving in the expiry cycle still wins.
          if (m_axil_bvalid) begin
            bready_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= m_axil_bresp;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end else if (to_expired) begin
            bready_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end
        end
        ST_RD_REQ: begin
          if (m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (m_axil_rvalid) begin
            rready_q      <= 1'b0;
            rsp_rdata_q   <= m_axil_rdata;
            rsp_resp_q    <= m_axil_rresp;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end else if (to_expired) begin
            rready_q      <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= RESP_SLVERR;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Ready stays low here so a late B/R is only ever taken in DRAIN.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (rsp_timeout_q) begin
              bready_q <= is_wr_q;
              rready_q <= !is_wr_q;
              state_q  <= ST_DRAIN;
            end else begin
              cmd_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
        end
        ST_DRAIN: begin
          if (is_wr_q ? m_axil_bvalid : m_axil_rvalid) begin
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = PROT_DEFAULT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = PROT_DEFAULT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule
